// File: rtl/alu_led_pkg.sv
// ALU LED pager shared types and helpers.
// Flag LED positions and page-count function.
package alu_led_pkg;

  localparam int SF_BIT = 2;
  localparam int CF_BIT = 1;
  localparam int OF_BIT = 0;

  typedef struct packed {
    logic zf;
    logic of;
    logic cf;
    logic sf;
  } alu_flags_t;

  // ZF sits on the top LED, so its position tracks the page width.
  function automatic int zf_bit(input int led_w);
    return led_w - 1;
  endfunction

  function automatic int npage(input int data_w, input int led_w);
    return data_w / led_w;
  endfunction

endpackage

// File: rtl/alu_led_if.sv
// ALU-side inputs and LED-side outputs of the pager.
// master drives ALU values and switches; slave is the pager.
interface alu_led_if #(
  parameter int DATA_W = 32,
  parameter int LED_W  = 8,
  parameter int SEL_W  = 3
);

  logic [DATA_W-1:0] F;
  logic              ZF;
  logic              OF;
  logic              CF;
  logic              SF;
  logic              cap_vld;
  logic [SEL_W-1:0]  sel;
  logic              auto_en;
  logic [LED_W-1:0]  LED;
  logic [SEL_W-1:0]  page;

  modport master (
    output F, ZF, OF, CF, SF,
    output cap_vld, sel, auto_en,
    input  LED, page
  );

  modport slave (
    input  F, ZF, OF, CF, SF,
    input  cap_vld, sel, auto_en,
    output LED, page
  );

endinterface

// File: rtl/alu_led_pager_timer.sv
// Cycle timer: counts 0..CYCLES-1 while enabled.
// tick is high during the last count of each period.
module led_dwell_timer #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  // Count while enabled; wrap on tick, zero on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_led_pager.sv
// LED pager: snapshots ALU result/flags, shows one page.
// Optional flag-page blink on overflow: ALU_LED_BLINK_EN.
module alu_led_pager
  import alu_led_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int LED_W     = 8,
  parameter int DWELL     = 50000000,
  parameter int BLINK_DIV = 12500000
) (
  input logic     clk,
  input logic     rst,
  alu_led_if.slave bus
);

  localparam int NPAGE  = npage(DATA_W, LED_W);
  localparam int SEL_W  = $clog2(NPAGE + 1);
  localparam int ZF_BIT = zf_bit(LED_W);
  localparam logic [SEL_W-1:0] FLAG_PG = SEL_W'(NPAGE);

  logic [DATA_W-1:0] snap_f;
  alu_flags_t        snap_fl;
  logic [SEL_W-1:0]  page_q;
  logic [SEL_W-1:0]  sel_c;
  logic [SEL_W-1:0]  page_adv;
  logic              auto_q;
  logic              scan_on;
  logic              dwell_tick;
  logic [LED_W-1:0]  flag_pat;
  logic [LED_W-1:0]  flag_show;
  logic [LED_W-1:0]  led_dat;
  logic [LED_W-1:0]  led_q;

  assign sel_c    = (bus.sel >= FLAG_PG) ? FLAG_PG : bus.sel;
  assign page_adv = (page_q == FLAG_PG) ? '0 : page_q + SEL_W'(1);
  assign scan_on  = bus.auto_en && auto_q;

  led_dwell_timer #(
    .CYCLES(DWELL)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .en  (scan_on),
    .clr (!scan_on),
    .tick(dwell_tick)
  );

  // Snapshot ALU result and flags on each capture strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_f  <= '0;
      snap_fl <= '0;
    end else if (bus.cap_vld) begin
      snap_f  <= bus.F;
      snap_fl <= '{zf: bus.ZF, of: bus.OF,
                   cf: bus.CF, sf: bus.SF};
    end
  end

  // Page select: switches in manual, dwell stepping in auto.
  // auto_q resets high so a scan running across reset
  // restarts at page 0 instead of reloading the switches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page_q <= '0;
      auto_q <= 1'b1;
    end else begin
      auto_q <= bus.auto_en;
      unique case (1'b1)
        !scan_on:   page_q <= sel_c;
        dwell_tick: page_q <= page_adv;
        default:    page_q <= page_q;
      endcase
    end
  end

  // Flag page layout.
  always_comb begin
    flag_pat         = '0;
    flag_pat[ZF_BIT] = snap_fl.zf;
    flag_pat[SF_BIT] = snap_fl.sf;
    flag_pat[CF_BIT] = snap_fl.cf;
    flag_pat[OF_BIT] = snap_fl.of;
  end

  // Data page slice for the current page.
  always_comb begin
    led_dat = '0;
    for (int p = 0; p < NPAGE; p++) begin
      if (page_q == SEL_W'(p)) begin
        led_dat = snap_f[p*LED_W +: LED_W];
      end
    end
  end

`ifdef ALU_LED_BLINK_EN
  logic blink_tick;
  logic blink_ph;

  led_dwell_timer #(
    .CYCLES(BLINK_DIV)
  ) u_blink (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (1'b0),
    .tick(blink_tick)
  );

  // Blink phase, starting in the lit half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_ph <= 1'b1;
    end else if (blink_tick) begin
      blink_ph <= ~blink_ph;
    end
  end

  assign flag_show = (snap_fl.of && !blink_ph) ? '0 : flag_pat;
`else
  assign flag_show = flag_pat;
`endif

  // Registered LED drive from the held page and snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= '0;
    end else if (page_q == FLAG_PG) begin
      led_q <= flag_show;
    end else begin
      led_q <= led_dat;
    end
  end

  assign bus.LED  = led_q;
  assign bus.page = page_q;

endmodule

// File: tb/tb_alu_led_pager.sv
// Directed scoreboard bench for alu_led_pager.
// DATA_W=32, LED_W=8, DWELL=4, BLINK_DIV=2.
module tb_alu_led_pager;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_led_if #(.DATA_W(32), .LED_W(8), .SEL_W(3)) bus ();

  alu_led_pager #(
    .DATA_W   (32),
    .LED_W    (8),
    .DWELL    (4),
    .BLINK_DIV(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string      tag;
    logic [7:0] led;
    logic [2:0] pg;
  } exp_t;

  exp_t exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] m_f;
  logic        m_zf, m_of, m_cf, m_sf;
  logic [2:0]  prev;
  logic [2:0]  seq [6];
  logic [7:0]  t2 [5];
  int          ones;

  function automatic logic [7:0] led_of(input logic [2:0] p);
    case (p)
      3'd0:    return m_f[7:0];
      3'd1:    return m_f[15:8];
      3'd2:    return m_f[23:16];
      3'd3:    return m_f[31:24];
      default: return {m_zf, 4'b0000, m_sf, m_cf, m_of};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [7:0] l,
                      input logic [2:0] p);
    exp_t e;
    e.tag = t;
    e.led = l;
    e.pg  = p;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string t, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", t, obs, exp);
  endtask

  task automatic check();
    exp_t e;
    if (exp_q.size() == 0) begin
      cmp("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      cmp(e.tag, 32'({bus.LED, 1'b0, bus.page}),
          32'({e.led, 1'b0, e.pg}));
    end
  endtask

  initial begin
    seq = '{3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2};
    t2  = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h82};

    rst         = 1'b1;
    bus.F       = 32'hFFFF_FFFF;
    bus.ZF      = 1'b1;
    bus.OF      = 1'b1;
    bus.CF      = 1'b1;
    bus.SF      = 1'b1;
    bus.cap_vld = 1'b1;
    bus.sel     = 3'd0;
    bus.auto_en = 1'b0;
    m_f  = '0;
    m_zf = 0; m_of = 0; m_cf = 0; m_sf = 0;

    // reset held with capture active
    #1;
    push("rst_async", 8'h00, 3'd0);
    check();
    for (int i = 0; i < 3; i++) begin
      push("rst_hold", 8'h00, 3'd0);
      step();
      check();
    end
    rst         = 1'b0;
    bus.cap_vld = 1'b0;
    push("no_load", 8'h00, 3'd0);
    step();
    step();
    check();

    // manual paging
    bus.F       = 32'h1234_5678;
    bus.ZF      = 1'b1;
    bus.OF      = 1'b0;
    bus.CF      = 1'b1;
    bus.SF      = 1'b0;
    bus.cap_vld = 1'b1;
    bus.sel     = 3'd0;
    push("cap_lat1", 8'h00, 3'd0);
    step();
    check();
    bus.cap_vld = 1'b0;
    m_f  = 32'h1234_5678;
    m_zf = 1; m_of = 0; m_cf = 1; m_sf = 0;
    push("cap_lat2", t2[0], 3'd0);
    step();
    check();
    for (int s = 1; s < 5; s++) begin
      bus.sel = 3'(s);
      push("sel_page", t2[s-1], 3'(s));
      step();
      check();
      push("sel_led", t2[s], 3'(s));
      step();
      check();
    end
    bus.sel = 3'd7;
    push("sel_clamp", 8'h82, 3'd4);
    step();
    check();

    // auto scan with a capture mid-dwell on page 1
    bus.sel     = 3'd2;
    bus.auto_en = 1'b1;
    prev        = 3'd4;
    for (int i = 0; i < 24; i++) begin
      push("auto_scan", led_of(prev), seq[i/4]);
      if (bus.cap_vld) m_f = bus.F;
      step();
      check();
      prev = seq[i/4];
      if (i == 17) begin
        bus.F       = 32'hAABB_CCDD;
        bus.cap_vld = 1'b1;
      end
      if (i == 18) bus.cap_vld = 1'b0;
    end
    bus.auto_en = 1'b0;
    bus.sel     = 3'd0;
    push("auto_drop", 8'hBB, 3'd0);
    step();
    check();

    // reset in the middle of a scan
    bus.sel     = 3'd3;
    bus.auto_en = 1'b1;
    push("rst_pre0", 8'hDD, 3'd3);
    step();
    check();
    push("rst_pre1", 8'hAA, 3'd3);
    step();
    check();
    rst = 1'b1;
    #1;
    push("rst_mid", 8'h00, 3'd0);
    check();
    m_f  = '0;
    m_zf = 0; m_of = 0; m_cf = 0; m_sf = 0;
    push("rst_mid_hold", 8'h00, 3'd0);
    step();
    check();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push("rst_dwell", 8'h00, (i == 3) ? 3'd1 : 3'd0);
      step();
      check();
    end

    // overflow flag page
    bus.auto_en = 1'b0;
    bus.sel     = 3'd4;
    bus.F       = 32'h0;
    bus.ZF      = 1'b0;
    bus.OF      = 1'b1;
    bus.CF      = 1'b0;
    bus.SF      = 1'b0;
    bus.cap_vld = 1'b1;
    push("of_cap", 8'h00, 3'd4);
    step();
    check();
    bus.cap_vld = 1'b0;
    m_of = 1;
`ifdef ALU_LED_BLINK_EN
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      cmp("blink_val", 32'(bus.LED & 8'hFE), 32'd0);
      if (bus.LED == 8'h01) ones++;
    end
    cmp("blink_duty", 32'(ones), 32'd4);
`else
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      push("flag_steady", led_of(3'd4), 3'd4);
      step();
      check();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
